// File: rtl/binary_to_gray_if.sv
// Bundle of the converter's qualified inputs and registered results.
// The master drives in_valid/binary/gray_in; the slave (converter) drives the outputs.
interface binary_to_gray_if #(
  parameter int unsigned WIDTH = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin_out;
  logic             out_valid;
  logic             adj_err;

  modport master (
    output in_valid, binary, gray_in,
    input  gray, bin_out, out_valid, adj_err
  );

  modport slave (
    input  in_valid, binary, gray_in,
    output gray, bin_out, out_valid, adj_err
  );
endinterface

// File: rtl/binary_to_gray.sv
// Registered binary->Gray encoder and parallel Gray->binary decoder, 1-cycle latency.
// Optional Gray-adjacency checker on the encoded stream is enabled by defining GRAY_CHECK_EN.
module binary_to_gray #(
  parameter int unsigned WIDTH = 3
) (
  input logic             clk,
  input logic             rst,
  binary_to_gray_if.slave bus
);

  logic [WIDTH-1:0] gray_d, gray_q;
  logic [WIDTH-1:0] bin_d, bin_q;
  logic             valid_d, valid_q;
  logic             adj_d, adj_q;
  logic [WIDTH-1:0] gray_enc;
  logic [WIDTH-1:0] bin_dec;

  always_comb begin
    gray_enc = bus.binary ^ (bus.binary >> 1);
    bin_dec  = '0;
    // Bit i of the decoded word is the XOR of all Gray bits from i up to the MSB.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_dec[i] = ^(bus.gray_in >> i);
    end
  end

  always_comb begin
    gray_d  = gray_q;
    bin_d   = bin_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      gray_d = gray_enc;
      bin_d  = bin_dec;
    end
  end

`ifdef GRAY_CHECK_EN
  logic have_prev_d, have_prev_q;

  // gray_q always holds the last accepted encoding, so it doubles as the history word.
  always_comb begin
    have_prev_d = have_prev_q | bus.in_valid;
    adj_d       = bus.in_valid & have_prev_q & ~$onehot(gray_enc ^ gray_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev_q <= 1'b0;
    end else begin
      have_prev_q <= have_prev_d;
    end
  end
`else
  always_comb begin
    adj_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      adj_q   <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      adj_q   <= adj_d;
    end
  end

  assign bus.gray      = gray_q;
  assign bus.bin_out   = bin_q;
  assign bus.out_valid = valid_q;
  assign bus.adj_err   = adj_q;

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed bench for binary_to_gray (WIDTH=3); expected results queued at drive time.
// Adjacency expectations follow GRAY_CHECK_EN when it is defined for the build.
module tb_binary_to_gray;

  typedef struct packed {
    logic [2:0] gray;
    logic [2:0] bin;
    logic       adj;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [2:0] enc_tbl [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [2:0] prev_gray = '0;
  bit         have_prev = 1'b0;

  binary_to_gray_if #(.WIDTH(3)) bus ();

  binary_to_gray #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inverse lookup in the encode table, independent of the prefix-XOR formula.
  function automatic logic [2:0] decode(input logic [2:0] g);
    logic [2:0] r = '0;
    for (int j = 0; j < 8; j++) begin
      if (enc_tbl[j] == g) r = 3'(j);
    end
    return r;
  endfunction

  task automatic step(input string tag, input bit v, input logic [2:0] b, input logic [2:0] g);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.binary   = b;
    bus.gray_in  = g;
    if (v) begin
      e.gray = enc_tbl[b];
      e.bin  = decode(g);
`ifdef GRAY_CHECK_EN
      e.adj  = have_prev && ($countones(e.gray ^ prev_gray) != 1);
`else
      e.adj  = 1'b0;
`endif
      prev_gray = e.gray;
      have_prev = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({tag, ".gray"}, 32'(bus.gray), 32'(e.gray));
        chk({tag, ".bin"}, 32'(bus.bin_out), 32'(e.bin));
        chk({tag, ".adj"}, 32'(bus.adj_err), 32'(e.adj));
      end
    end
  endtask

  task automatic reset_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.binary   = 3'b101;
      bus.gray_in  = 3'b110;
      @(posedge clk);
      #1;
      chk({tag, ".gray"}, 32'(bus.gray), 32'(0));
      chk({tag, ".bin"}, 32'(bus.bin_out), 32'(0));
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(0));
      chk({tag, ".adj"}, 32'(bus.adj_err), 32'(0));
    end
    prev_gray = '0;
    have_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.binary   = 3'b101;
    bus.gray_in  = 3'b000;

    reset_cycles("reset", 2);

    // Sweep encode while round-tripping the table through the decoder.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sweep%0d", i), 1'b1, 3'(i), enc_tbl[i]);
    end

    step("hold_acc", 1'b1, 3'b011, 3'b111);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("hold%0d", k), 1'b0, 3'b110, 3'b001);
      chk($sformatf("hold%0d.gray", k), 32'(bus.gray), 32'(3'b010));
      chk($sformatf("hold%0d.bin", k), 32'(bus.bin_out), 32'(3'b101));
    end

    step("wrap_hi", 1'b1, 3'b111, 3'b100);
    step("wrap_lo", 1'b1, 3'b000, 3'b000);

    step("chk_a", 1'b1, 3'b000, 3'b010);
    step("chk_b", 1'b1, 3'b011, 3'b011);
    step("chk_jump", 1'b1, 3'b101, 3'b101);
    step("chk_same", 1'b1, 3'b101, 3'b111);

    // Back-to-back random traffic, interleaved with idle cycles.
    for (int k = 0; k < 20; k++) begin
      step($sformatf("rnd%0d", k), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    end

    // Mid-stream reset discards the input and clears adjacency history.
    step("pre_rst", 1'b1, 3'b101, 3'b101);
    reset_cycles("mid_reset", 1);
    step("post_rst", 1'b1, 3'b010, 3'b011);
    step("post_rst2", 1'b1, 3'b100, 3'b110);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
